// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Allocates one tag per dispatched
// instruction, records CDB completions, retires at most one completed
// instruction per cycle from the head, and serves operand lookups with a
// same-cycle CDB bypass. Tag = slot index + 1; tag 0 means "no tag".
module reorder_buffer #(
    parameter int ROB_SZ = 8,
    parameter int TAG_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              dispatch_valid,
    input  logic              dispatch_rd_valid,
    input  logic [4:0]        dispatch_dest_reg,
    input  logic [31:0]       dispatch_pc,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_rob_tag,
    input  logic [31:0]       cdb_value,
    input  logic [TAG_W-1:0]  read_tag_a,
    input  logic [TAG_W-1:0]  read_tag_b,
    output logic              dispatch_ready,
    output logic [TAG_W-1:0]  tail_tag,
    output logic              rob_full,
    output logic              rob_empty,
    output logic [TAG_W:0]    rob_count,
    output logic              retire_valid,
    output logic [TAG_W-1:0]  retire_tag,
    output logic              retire_rd_valid,
    output logic [4:0]        retire_dest_reg,
    output logic [31:0]       retire_value,
    output logic [31:0]       retire_pc,
    output logic              read_ready_a,
    output logic              read_ready_b,
    output logic [31:0]       read_value_a,
    output logic [31:0]       read_value_b
);

    localparam int PTR_W = $clog2(ROB_SZ);
    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(ROB_SZ);
    localparam logic [TAG_W-1:0] MAX_TAG    = TAG_W'(ROB_SZ);

    // Control state: reset asynchronously.
    logic [ROB_SZ-1:0] valid_reg;
    logic [ROB_SZ-1:0] complete_reg;
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [TAG_W:0]    count_reg;

    // Payload storage: only meaningful while the slot is valid, so no reset.
    logic              rd_valid_mem [ROB_SZ];
    logic [4:0]        dest_mem     [ROB_SZ];
    logic [31:0]       pc_mem       [ROB_SZ];
    logic [31:0]       value_mem    [ROB_SZ];

    logic              accept;
    logic              retire;
    logic              cdb_hit;
    logic [PTR_W-1:0]  cdb_slot;

    function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
        return (tag != '0) && (tag <= MAX_TAG);
    endfunction

    function automatic logic [PTR_W-1:0] tag_to_slot(input logic [TAG_W-1:0] tag);
        return PTR_W'(tag - TAG_W'(1));
    endfunction

    assign rob_full       = (count_reg == FULL_COUNT);
    assign rob_empty      = (count_reg == '0);
    assign rob_count      = count_reg;
    assign dispatch_ready = !rob_full;
    assign tail_tag       = TAG_W'(tail_reg) + TAG_W'(1);

    // Dispatch uses the registered count only: a retire in the same cycle
    // does not make room for a dispatch while full.
    assign accept   = dispatch_valid && !rob_full;
    assign retire   = valid_reg[head_reg] && complete_reg[head_reg];
    assign cdb_slot = tag_to_slot(cdb_rob_tag);
    assign cdb_hit  = cdb_valid && tag_in_range(cdb_rob_tag) && valid_reg[cdb_slot];

    assign retire_valid    = retire;
    assign retire_tag      = retire ? TAG_W'(head_reg) + TAG_W'(1) : '0;
    assign retire_rd_valid = retire ? rd_valid_mem[head_reg] : 1'b0;
    assign retire_dest_reg = retire ? dest_mem[head_reg] : '0;
    assign retire_value    = retire ? value_mem[head_reg] : '0;
    assign retire_pc       = retire ? pc_mem[head_reg] : '0;

    // Pointers, count and per-slot valid/complete; retire is applied last so
    // a CDB aimed at the retiring head cannot resurrect it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_reg    <= '0;
            complete_reg <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (flush) begin
            valid_reg    <= '0;
            complete_reg <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            if (accept) begin
                valid_reg[tail_reg]    <= 1'b1;
                complete_reg[tail_reg] <= 1'b0;
                tail_reg               <= tail_reg + PTR_W'(1);
            end
            if (cdb_hit) begin
                complete_reg[cdb_slot] <= 1'b1;
            end
            if (retire) begin
                valid_reg[head_reg]    <= 1'b0;
                complete_reg[head_reg] <= 1'b0;
                head_reg               <= head_reg + PTR_W'(1);
            end
            count_reg <= count_reg + (TAG_W+1)'(accept) - (TAG_W+1)'(retire);
        end
    end

    // Payload writes: dispatch fields at the tail, CDB result into its slot.
    always_ff @(posedge clock) begin
        if (accept) begin
            rd_valid_mem[tail_reg] <= dispatch_rd_valid;
            dest_mem[tail_reg]     <= dispatch_dest_reg;
            pc_mem[tail_reg]       <= dispatch_pc;
        end
        if (cdb_hit) begin
            value_mem[cdb_slot] <= cdb_value;
        end
    end

    logic [TAG_W-1:0] rd_tag   [2];
    logic             rd_ready [2];
    logic [31:0]      rd_value [2];

    assign rd_tag[0]    = read_tag_a;
    assign rd_tag[1]    = read_tag_b;
    assign read_ready_a = rd_ready[0];
    assign read_ready_b = rd_ready[1];
    assign read_value_a = rd_value[0];
    assign read_value_b = rd_value[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic [PTR_W-1:0] slot;
            logic             live;
            logic             bypass;
            assign slot   = tag_to_slot(rd_tag[gi]);
            assign live   = tag_in_range(rd_tag[gi]) && valid_reg[slot];
            assign bypass = cdb_valid && (cdb_rob_tag == rd_tag[gi]);

            // Operand lookup: a matching CDB broadcast wins over stored value.
            always_comb begin
                rd_ready[gi] = 1'b0;
                rd_value[gi] = '0;
                if (live && bypass) begin
                    rd_ready[gi] = 1'b1;
                    rd_value[gi] = cdb_value;
                end else if (live && complete_reg[slot]) begin
                    rd_ready[gi] = 1'b1;
                    rd_value[gi] = value_mem[slot];
                end
            end
        end
    endgenerate

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular in-order instruction buffer, sitting between dispatch and the map table / retire logic. It allocates one ROB tag per dispatched instruction and records completion and results broadcast on the CDB. It retires at most one completed instruction per cycle from the head. It supplies the tail tag written into the map table, the head tag used to clear map entries, and operand value/ready reads for t_plus (in-ROB) operands.

Parameters:
ROB_SZ, 8, number of entries; power of two, 2..32
TAG_W, 4, tag width; must satisfy 2^TAG_W > ROB_SZ

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
flush  in  1  synchronous squash of all entries
dispatch_valid  in  1  dispatch request
dispatch_rd_valid  in  1  instruction writes a destination register
dispatch_dest_reg  in  5  architectural destination index
dispatch_pc  in  32  instruction PC
cdb_valid  in  1  CDB broadcast valid
cdb_rob_tag  in  TAG_W  completing tag
cdb_value  in  32  result value
read_tag_a  in  TAG_W  operand A lookup tag
read_tag_b  in  TAG_W  operand B lookup tag
dispatch_ready  out  1  entry available (!rob_full)
tail_tag  out  TAG_W  tag assigned to this cycle's dispatch
rob_full  out  1  count == ROB_SZ
rob_empty  out  1  count == 0
rob_count  out  TAG_W+1  occupied entries
retire_valid  out  1  head entry valid and complete
retire_tag  out  TAG_W  head tag
retire_rd_valid  out  1  head writes a register
retire_dest_reg  out  5  head destination
retire_value  out  32  head result
retire_pc  out  32  head PC
read_ready_a / read_ready_b  out  1  operand value available
read_value_a / read_value_b  out  32  operand value

Behaviour:
- Tag encoding: tag = slot index + 1. Tag 0 is reserved as "no tag", matching the map table's empty encoding, and never issued.
- Per-entry state: valid, complete, rd_valid, dest_reg, pc, value. Head and tail pointers are log2(ROB_SZ) bits and wrap modulo ROB_SZ. Count is a separate register.
- Reset (reset==0, async): all valid/complete = 0; head = tail = 0; count = 0. Outputs are then rob_empty=1, rob_full=0, dispatch_ready=1, tail_tag=1, retire_valid=0, retire_* = 0, read_ready_* = 0, read_value_* = 0. Reset applies immediately mid-operation and discards all in-flight state.
- Dispatch: accepted at the clock edge iff dispatch_valid && !rob_full, using registered count (no same-cycle retire bypass). The slot at tail gets valid=1, complete=0 and the dispatch fields; tail advances by 1. When full, dispatch_valid is ignored with no state change.
- CDB: if cdb_valid, cdb_rob_tag != 0 and the tagged slot is valid, set complete=1 and value=cdb_value at the edge. A CDB for tag 0, an out-of-range tag or an invalid slot is ignored. Repeated CDB to a completed slot overwrites the value.
- Retire: retire_valid and retire_* are combinational from the head slot. retire_* = 0 when retire_valid=0. When retire_valid=1 the head slot is cleared and head advances at the edge. There is no stall input; retirement is unconditional. At most one retire per cycle.
- Dispatch + retire in the same cycle: count unchanged. Dispatch + retire with full=1: retire only.
- CDB to the tail slot in the same cycle as its dispatch: ignored, because the slot is invalid pre-edge. The new entry has complete=0.
- Operand read (combinational): read_ready_x = 1 if the tagged slot is valid && complete, or if cdb_valid && cdb_rob_tag == read_tag_x && the slot is valid (same-cycle bypass, value = cdb_value). read_tag 0 or an invalid slot gives ready=0, value=0.
- flush (synchronous, active high): at the edge, clear all entries, head = tail = 0, count = 0. Flush has priority over dispatch, CDB and retire in that cycle. retire_valid is still driven combinationally during the flush cycle.
- Count arithmetic: count' = count + accept − retire. It is never >ROB_SZ and never <0.

Test Plan:
- Reset then release: rob_empty=1, tail_tag=1, retire_valid=0. Dispatch 3 instructions (rd=5,6,7) -> tags 1,2,3 issued, rob_count=3, tail_tag=4.
- Fill 8 entries with no CDB -> rob_full=1, dispatch_ready=0. A 9th dispatch_valid causes no change; tail_tag stays 1 after wrap.
- Out-of-order completion: CDB tag 2 value 0xAA, then tag 1 value 0xBB -> retire_valid asserts only after tag 1 completes. Retires tag 1 (0xBB) then tag 2 (0xAA) on consecutive cycles.
- Full ROB with head complete, plus dispatch_valid in the same cycle -> only the retire occurs and count goes 8->7. Next cycle the dispatch is accepted and its tail_tag equals the freed slot's tag.
- Operand bypass: entry tag 3 incomplete, read_tag_a=3, CDB tag 3 value 0x1234 in the same cycle -> read_ready_a=1, read_value_a=0x1234. read_tag_b=0 -> read_ready_b=0.
- Flush with 5 entries plus a concurrent dispatch and CDB -> next cycle rob_empty=1, tail_tag=1, retire_valid=0. Drive reset low mid-burst -> outputs at reset values before the next clock edge.
